// File: rtl/ahb_pkg.sv
// AHB-Lite shared types, constants and address-phase helper functions.
//   htrans_t     : transfer type encoding
//   HSIZE_*      : transfer size codes
//   HRESP_*      : response codes
//   byte_lanes() : byte-lane enables for a (size, addr[1:0]) pair
//   is_legal()   : size supported and naturally aligned
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Sizes above a word fall back to all lanes; misaligned halfwords lose the
    // lane shifted out of the word.
    function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] addr);
        logic [3:0] lanes;
        case (size)
            HSIZE_BYTE: lanes = 4'(4'b0001 << addr);
            HSIZE_HALF: lanes = 4'(4'b0011 << addr);
            default:    lanes = 4'hF;
        endcase
        return lanes;
    endfunction

    function automatic logic is_legal(input logic [2:0] size, input logic [1:0] addr);
        return (size <= HSIZE_WORD)
            && !((size == HSIZE_HALF) && addr[0])
            && !((size == HSIZE_WORD) && (addr != 2'b00));
    endfunction

endpackage

// File: rtl/ram_sp_be.sv
// 32-bit word RAM with per-byte write enables and a registered read port.
// Written so FPGA tools infer block RAM; contents are never reset.
//   clk_i   : clock
//   we_i    : byte write enables
//   waddr_i : write word address
//   wdata_i : write data
//   re_i    : read enable; rdata_o updates only when set
//   raddr_i : read word address
//   rdata_o : registered read data (old contents on same-edge write)
module ram_sp_be #(
    parameter int unsigned AW = 10
) (
    input  logic          clk_i,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    // Byte-lane write and registered read
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i[b]) begin
                mem[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ahb_ram_ws.sv
// AHB-Lite slave RAM with configurable wait states, write-to-read forwarding
// and a two-cycle ERROR response for illegal or misaligned transfers.
//   HCLK, HRESETn            : clock, async active-low reset
//   HSEL, HREADY, HTRANS     : address-phase qualification
//   HADDR, HWRITE, HSIZE     : address-phase control (latched on accept)
//   HWDATA                   : write data, used at the final data-phase edge
//   HREADYOUT, HRESP, HRDATA : data-phase response
module ahb_ram_ws
    import ahb_pkg::*;
#(
    parameter int unsigned MEMWIDTH    = 12,
    parameter int unsigned WAIT_STATES = 0,
    parameter bit          ERR_CHECK   = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic        HREADY,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int unsigned AW    = MEMWIDTH - 2;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [AW-1:0]    addr_q;
    logic [3:0]       lanes_q;
    logic             write_q;
    logic             hreadyout_q;
    logic             hresp_q;
    logic [3:0]       fwd_lanes_q;
    logic [31:0]      fwd_data_q;

    logic             accept_c;
    logic             legal_c;
    logic             take_c;
    logic             okay_c;
    logic             bad_c;
    logic             commit_c;
    logic             issue_rd_c;
    logic [AW-1:0]    req_addr_c;
    logic [3:0]       req_lanes_c;
    logic [3:0]       wr_lanes_c;
    logic [3:0]       fwd_lanes_c;
    logic [31:0]      ram_rdata;
    logic [31:0]      merged_c;
    logic [31:0]      lane_mask_c;
    logic             unused_bits;

    assign accept_c    = HSEL & HREADY & HTRANS[1];
    assign legal_c     = !ERR_CHECK || is_legal(HSIZE, HADDR[1:0]);
    // A new address phase can only be taken when no data phase is stalling
    assign take_c      = (state_q == ST_IDLE) || (state_q == ST_ERR2)
                      || ((state_q == ST_DATA) && (cnt_q == '0));
    assign okay_c      = take_c & accept_c & legal_c;
    assign bad_c       = take_c & accept_c & !legal_c;
    assign issue_rd_c  = okay_c & !HWRITE;
    assign req_addr_c  = HADDR[MEMWIDTH-1:2];
    assign req_lanes_c = byte_lanes(HSIZE, HADDR[1:0]);

    // Write commits on the last edge of its data phase
    assign commit_c    = (state_q == ST_DATA) && (cnt_q == '0) && write_q;
    assign wr_lanes_c  = commit_c ? lanes_q : 4'b0000;

    // RAM returns pre-write contents for a same-edge read; patch those lanes
    assign fwd_lanes_c = (issue_rd_c && commit_c && (addr_q == req_addr_c)) ? lanes_q : 4'b0000;

    assign unused_bits = ^{HADDR[31:MEMWIDTH], HTRANS[0]};

    ram_sp_be #(
        .AW (AW)
    ) u_ram (
        .clk_i   (HCLK),
        .we_i    (wr_lanes_c),
        .waddr_i (addr_q),
        .wdata_i (HWDATA),
        .re_i    (issue_rd_c),
        .raddr_i (req_addr_c),
        .rdata_o (ram_rdata)
    );

    // Transfer FSM, wait counter and registered response
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            lanes_q     <= '0;
            write_q     <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            fwd_lanes_q <= '0;
            fwd_data_q  <= '0;
        end else begin
            if (issue_rd_c) begin
                fwd_lanes_q <= fwd_lanes_c;
                fwd_data_q  <= HWDATA;
            end

            if (state_q == ST_ERR1) begin
                state_q     <= ST_ERR2;
                hreadyout_q <= 1'b1;
                hresp_q     <= HRESP_ERROR;
            end else if ((state_q == ST_DATA) && (cnt_q != '0)) begin
                cnt_q       <= cnt_q - CNT_W'(1);
                hreadyout_q <= (cnt_q == CNT_W'(1));
            end else if (okay_c) begin
                state_q     <= ST_DATA;
                cnt_q       <= CNT_W'(WAIT_STATES);
                addr_q      <= req_addr_c;
                lanes_q     <= req_lanes_c;
                write_q     <= HWRITE;
                hreadyout_q <= (WAIT_STATES == 0);
                hresp_q     <= HRESP_OKAY;
            end else if (bad_c) begin
                state_q     <= ST_ERR1;
                write_q     <= 1'b0;
                hreadyout_q <= 1'b0;
                hresp_q     <= HRESP_ERROR;
            end else begin
                state_q     <= ST_IDLE;
                write_q     <= 1'b0;
                hreadyout_q <= 1'b1;
                hresp_q     <= HRESP_OKAY;
            end
        end
    end

    // Read result with forwarded lanes merged in
    always_comb begin
        merged_c = ram_rdata;
        for (int b = 0; b < 4; b++) begin
            if (fwd_lanes_q[b]) begin
                merged_c[b*8 +: 8] = fwd_data_q[b*8 +: 8];
            end
        end
    end

    assign lane_mask_c = {{8{lanes_q[3]}}, {8{lanes_q[2]}}, {8{lanes_q[1]}}, {8{lanes_q[0]}}};

    // Driven only from registers through lane masking
    assign HRDATA    = ((state_q == ST_DATA) && !write_q) ? (merged_c & lane_mask_c) : 32'h0;
    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;

endmodule

// File: tb/tb_ahb_ram_ws.sv
`timescale 1ns/1ps
module tb_ahb_ram_ws;
    import ahb_pkg::*;

    localparam int unsigned WS1 = 3;

    logic        clk = 1'b0;
    logic        hresetn;
    logic        hsel0, hsel1;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        ro0, resp0, ro1, resp1;
    logic [31:0] rd0, rd1;

    int checks = 0;
    int fails  = 0;

    // Reference memory image per DUT, byte-addressed semantics
    logic [31:0] model_mem [2][1024];

    always #5 clk = ~clk;

    ahb_ram_ws #(.MEMWIDTH(12), .WAIT_STATES(0), .ERR_CHECK(1'b1)) dut0 (
        .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel0), .HREADY(ro0), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
        .HREADYOUT(ro0), .HRESP(resp0), .HRDATA(rd0));

    ahb_ram_ws #(.MEMWIDTH(12), .WAIT_STATES(WS1), .ERR_CHECK(1'b1)) dut1 (
        .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel1), .HREADY(ro1), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
        .HREADYOUT(ro1), .HRESP(resp1), .HRDATA(rd1));

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic ready_of(input int d);
        return (d == 1) ? ro1 : ro0;
    endfunction
    function automatic logic resp_of(input int d);
        return (d == 1) ? resp1 : resp0;
    endfunction
    function automatic logic [31:0] rdata_of(input int d);
        return (d == 1) ? rd1 : rd0;
    endfunction

    // Unsupported size or not aligned to its own size
    function automatic logic bad_req(input logic [2:0] sz, input logic [31:0] addr);
        if (sz > 3'd2) return 1'b1;
        return (addr % (32'd1 << sz)) != 0;
    endfunction

    function automatic void model_write(input int d, input logic [31:0] addr, input logic [2:0] sz,
                                        input logic [31:0] wdata);
        int w = int'((addr % 4096) / 4);
        int first = int'(addr % 4);
        for (int i = first; i < first + (1 << sz); i++) begin
            model_mem[d][w][8*i +: 8] = wdata[8*i +: 8];
        end
    endfunction

    function automatic logic [31:0] model_read(input int d, input logic [31:0] addr, input logic [2:0] sz);
        logic [31:0] r = 32'h0;
        int w = int'((addr % 4096) / 4);
        int first = int'(addr % 4);
        for (int i = first; i < first + (1 << sz); i++) begin
            r[8*i +: 8] = model_mem[d][w][8*i +: 8];
        end
        return r;
    endfunction

    // One non-pipelined transfer; junk on the address bus during the data phase
    task automatic do_xfer(input int d, input logic wr, input logic [2:0] sz, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata,
                           output logic resp, output int waits);
        hsel0 = (d == 0); hsel1 = (d == 1);
        htrans = HTRANS_NONSEQ; haddr = addr; hwrite = wr; hsize = sz;
        @(posedge clk); #1;
        hsel0 = 1'b0; hsel1 = 1'b0; htrans = HTRANS_IDLE; hwdata = wdata;
        haddr = $urandom(); hwrite = ~wr; hsize = 3'($urandom_range(0, 7));
        waits = 0;
        while (ready_of(d) == 1'b0 && waits < 20) begin
            @(posedge clk); #1;
            waits++;
        end
        resp  = resp_of(d);
        rdata = rdata_of(d);
        @(posedge clk); #1;
    endtask

    task automatic run_checked(input int d, input logic wr, input logic [2:0] sz, input logic [31:0] addr,
                               input logic [31:0] wdata, output logic [31:0] rdata);
        logic        bad;
        logic        resp;
        int          waits;
        int          exp_w;
        logic [31:0] exp_rd;
        string       tag;
        bad    = bad_req(sz, addr);
        exp_w  = bad ? 1 : ((d == 1) ? int'(WS1) : 0);
        exp_rd = (wr || bad) ? 32'h0 : model_read(d, addr, sz);
        tag    = $sformatf("d%0d_%s_sz%0d_a%08h", d, wr ? "wr" : "rd", sz, addr);
        do_xfer(d, wr, sz, addr, wdata, rdata, resp, waits);
        check({tag, "_resp"}, 32'(resp), 32'(bad));
        check({tag, "_waits"}, 32'(waits), 32'(exp_w));
        check({tag, "_rdata"}, rdata, exp_rd);
        if (wr && !bad) model_write(d, addr, sz, wdata);
    endtask

    // Write address phase immediately followed by a read address phase on DUT0
    task automatic pipe_wr_rd(input logic [31:0] waddr, input logic [2:0] wsz, input logic [31:0] wdata,
                              input logic [31:0] raddr, input logic [2:0] rsz, input string tag);
        logic [31:0] exp_rd;
        hsel0 = 1'b1; htrans = HTRANS_NONSEQ; haddr = waddr; hwrite = 1'b1; hsize = wsz;
        @(posedge clk); #1;
        haddr = raddr; hwrite = 1'b0; hsize = rsz; hwdata = wdata;
        @(posedge clk); #1;
        hsel0 = 1'b0; htrans = HTRANS_IDLE; hwdata = $urandom();
        model_write(0, waddr, wsz, wdata);
        exp_rd = model_read(0, raddr, rsz);
        check({tag, "_rdata"}, rd0, exp_rd);
        check({tag, "_ready"}, 32'(ro0), 32'd1);
        check({tag, "_resp"}, 32'(resp0), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rdata;
        logic [31:0] old_word;

        hresetn = 1'b0; hsel0 = 1'b0; hsel1 = 1'b0; haddr = '0; htrans = HTRANS_IDLE;
        hwrite = 1'b0; hsize = HSIZE_WORD; hwdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready0", 32'(ro0), 32'd1);
        check("reset_resp0", 32'(resp0), 32'd0);
        check("reset_rdata0", rd0, 32'h0);
        check("reset_ready1", 32'(ro1), 32'd1);
        check("reset_resp1", 32'(resp1), 32'd0);
        check("reset_rdata1", rd1, 32'h0);
        hresetn = 1'b1;
        @(posedge clk); #1;

        // Known contents for the low 64 words of both RAMs
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 64; w++) begin
                run_checked(d, 1'b1, HSIZE_WORD, 32'(w * 4), 32'h0, rdata);
            end
        end

        // Zero-wait word write then read
        run_checked(0, 1'b1, HSIZE_WORD, 32'h10, 32'hDEADBEEF, rdata);
        run_checked(0, 1'b0, HSIZE_WORD, 32'h10, 32'h0, rdata);
        check("t1_word_read", rdata, 32'hDEADBEEF);

        // Byte writes with replicated lanes; only the addressed lane may land
        run_checked(0, 1'b1, HSIZE_BYTE, 32'h21, 32'h11111111, rdata);
        run_checked(0, 1'b1, HSIZE_BYTE, 32'h23, 32'h22222222, rdata);
        run_checked(0, 1'b0, HSIZE_WORD, 32'h20, 32'h0, rdata);
        check("t2_word_read", rdata, 32'h22001100);
        run_checked(0, 1'b0, HSIZE_BYTE, 32'h23, 32'h0, rdata);
        check("t2_byte_read", rdata, 32'h22000000);

        // Read accepted on the edge the write to the same word commits
        pipe_wr_rd(32'h40, HSIZE_WORD, 32'hA5A5A5A5, 32'h40, HSIZE_WORD, "t3_hazard_word");
        check("t3_hazard_value", model_read(0, 32'h40, HSIZE_WORD), 32'hA5A5A5A5);
        pipe_wr_rd(32'h42, HSIZE_BYTE, 32'hFF5AFFFF, 32'h40, HSIZE_WORD, "t3_hazard_byte");
        pipe_wr_rd(32'h44, HSIZE_WORD, 32'h0BADF00D, 32'h48, HSIZE_WORD, "t3_other_word");
        pipe_wr_rd(32'h1046, HSIZE_HALF, 32'h7E7E7E7E, 32'h44, HSIZE_WORD, "t3_hazard_wrap");

        // Three-wait write: storage untouched until the final edge
        old_word = model_mem[1][12];
        hsel1 = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h30; hwrite = 1'b1; hsize = HSIZE_WORD;
        @(posedge clk); #1;
        hsel1 = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'h12345678; haddr = 32'h34; hwrite = 1'b0;
        for (int i = 0; i < int'(WS1); i++) begin
            check($sformatf("t4_stall%0d_ready", i), 32'(ro1), 32'd0);
            check($sformatf("t4_stall%0d_mem", i), dut1.u_ram.mem[12], old_word);
            @(posedge clk); #1;
        end
        check("t4_last_ready", 32'(ro1), 32'd1);
        check("t4_last_resp", 32'(resp1), 32'd0);
        check("t4_last_mem", dut1.u_ram.mem[12], old_word);
        @(posedge clk); #1;
        check("t4_committed_mem", dut1.u_ram.mem[12], 32'h12345678);
        model_write(1, 32'h30, HSIZE_WORD, 32'h12345678);
        run_checked(1, 1'b0, HSIZE_WORD, 32'h30, 32'h0, rdata);
        check("t4_read_value", rdata, 32'h12345678);

        // Misaligned halfword write, next transfer presented through the error
        hsel0 = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h01; hwrite = 1'b1; hsize = HSIZE_HALF;
        @(posedge clk); #1;
        hwdata = 32'hFFFFFFFF; haddr = 32'h20; hwrite = 1'b0; hsize = HSIZE_WORD;
        check("t5_err1_ready", 32'(ro0), 32'd0);
        check("t5_err1_resp", 32'(resp0), 32'd1);
        @(posedge clk); #1;
        check("t5_err2_ready", 32'(ro0), 32'd1);
        check("t5_err2_resp", 32'(resp0), 32'd1);
        @(posedge clk); #1;
        hsel0 = 1'b0; htrans = HTRANS_IDLE;
        check("t5_next_resp", 32'(resp0), 32'd0);
        check("t5_next_ready", 32'(ro0), 32'd1);
        check("t5_next_rdata", rd0, 32'h22001100);
        @(posedge clk); #1;
        run_checked(0, 1'b0, HSIZE_WORD, 32'h00, 32'h0, rdata);
        check("t5_mem_untouched", rdata, 32'h0);

        // Random traffic over both wait-state configurations, with address wrap
        for (int n = 0; n < 160; n++) begin
            int          d;
            logic        wr;
            logic [2:0]  sz;
            logic [31:0] addr;
            d    = int'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            sz   = 3'($urandom_range(0, 3));
            addr = ($urandom() & 32'hFFFF_F000) | 32'($urandom_range(0, 255));
            run_checked(d, wr, sz, addr, $urandom(), rdata);
        end

        // Reset in the middle of a stalled write
        old_word = model_mem[1][32];
        hsel1 = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h80; hwrite = 1'b1; hsize = HSIZE_WORD;
        @(posedge clk); #1;
        hsel1 = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        check("t6_pre_ready", 32'(ro1), 32'd0);
        hresetn = 1'b0;
        #1;
        check("t6_rst_ready", 32'(ro1), 32'd1);
        check("t6_rst_resp", 32'(resp1), 32'd0);
        check("t6_rst_rdata", rd1, 32'h0);
        @(posedge clk); #1;
        hresetn = 1'b1;
        @(posedge clk); #1;
        run_checked(1, 1'b0, HSIZE_WORD, 32'h80, 32'h0, rdata);
        check("t6_word_kept", rdata, old_word);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
